fpu_aux_wb_buffer: RTL
======================

Name: fpu_aux_wb_buffer

Overview:
- Writeback buffer directly downstream of the FPU aux stage (FMIN/FMAX, FSGNJ*, FCVT.S.W[U], FMV.W.X).
- Captures the aux stage's recoded result, its destination register and its fflags in a 2-entry FIFO.
- Presents the head entry to the FP register-file write arbiter with a valid/yumi handshake.
- Accumulates the sticky fflags of retired entries for the fcsr.

Parameters:
- sig_width_p, fpu_recoded_sig_width_gp, recoded significand width.
- exp_width_p, fpu_recoded_exp_width_gp, recoded exponent width.
- reg_addr_width_p, RV32_reg_addr_width_gp, destination register index width.
- recoded_data_width_lp, 1+sig_width_p+exp_width_p, derived, not overridable.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  aux stage result valid.
- ready_o  out  1  buffer can accept an entry this cycle.
- rd_i  in  reg_addr_width_p  destination FP register.
- result_i  in  recoded_data_width_lp  recoded result.
- fflags_i  in  fflags_s  exception flags of result_i.
- v_o  out  1  head entry valid.
- rd_o  out  reg_addr_width_p  head destination register.
- result_o  out  recoded_data_width_lp  head result.
- yumi_i  in  1  arbiter consumes head this cycle.
- fflags_w_v_i  in  1  CSR write of fflags.
- fflags_w_data_i  in  fflags_s  CSR write data.
- fflags_o  out  fflags_s  accumulated sticky flags.
- pending_o  out  1  buffer non-empty (for fence/CSR-read stall).

Behaviour:
- Clock and reset: single clock clk_i. reset_n_i asserted low clears all state asynchronously, independent of clk_i.
  - Count = 0, read/write pointers = 0.
  - Storage (rd, result, fflags) = 0.
  - fflags accumulator = 0.
  - Outputs after reset: v_o=0, ready_o=1, pending_o=0, rd_o=0, result_o=0, fflags_o=0.
- Reset mid-operation: all in-flight entries are discarded, with no fflags contribution. The first enqueue after deassertion behaves as from empty.
- Storage: 2-entry circular FIFO.
  - 1-bit read and write pointers, 2-bit count (0..2).
  - Pointers wrap 1 -> 0.
- Handshakes:
  - ready_o = (count != 2). Purely a function of state, with no combinational dependence on yumi_i.
  - Enqueue when v_i & ready_o: write {rd_i, result_i, fflags_i} at the write pointer, then increment the write pointer.
  - v_i while ready_o=0 is a protocol error. The entry is dropped; the upstream stage must hold.
  - v_o = (count != 0). rd_o and result_o are the head entry, registered with no input bypass.
  - Latency: v_i in cycle N gives v_o in cycle N+1 at the earliest.
  - Dequeue when yumi_i & v_o, then increment the read pointer. yumi_i while v_o=0 is ignored.
  - Simultaneous enqueue and dequeue at count=1: count stays 1, both pointers advance.
  - At count=2, no enqueue is possible in the same cycle as a dequeue, because ready_o=0. There is no pass-through.
  - pending_o = v_o.
- fflags accumulation (sticky):
  - next = (fflags_w_v_i ? fflags_w_data_i : fflags_r) | (deq ? head.fflags : 0).
  - A CSR write in the same cycle as a dequeue never loses the dequeued flags.
  - Clearing is a CSR write of 0.
  - Flags are accumulated on dequeue only, never on enqueue.
- Payload contents: result and rd are stored unmodified, with no recoding.

Test Plan:
- Reset then idle: reset_n_i=0 for 3 cycles, then release. Required: v_o=0, ready_o=1, fflags_o=5'b0, pending_o=0 every cycle.
- Single pass: v_i=1, rd_i=5'd7, result_i=33'h0_8000_0000, fflags_i=invalid, in cycle N, yumi_i held high. Required: v_o=1, rd_o=7, result_o=33'h0_8000_0000 in cycle N+1; v_o=0 in N+2; fflags_o=5'b10000 from N+2.
- Fill and backpressure: 3 back-to-back v_i with rd 1,2,3 and yumi_i=0.
  - Required: ready_o=0 after the second accept, so upstream holds the third entry.
  - Then yumi_i=1 for 4 cycles. Required: rd_o sequence 1,2,3 in order, ready_o returns to 1, pointer wrap exercised.
- Concurrent enq/deq at count=1 for 10 cycles with incrementing rd. Required: count stays 1, every rd appears exactly once in order.
- CSR collision: fflags_o=5'b00001, then fflags_w_v_i=1 with data 0 in the same cycle as dequeue of an entry with overflow set. Required: fflags_o=5'b00100 next cycle.
- Async reset mid-operation: 2 entries queued, reset_n_i pulsed low between clock edges. Required: v_o=0 and fflags_o=0 immediately, not waiting for an edge; a later single enqueue appears alone on the output.

Source files
------------

// File: rtl/fpu_aux_wb_buffer_if.sv
// Flag type shared by the aux writeback buffer and its handshake interface.
package fpu_aux_wb_pkg;
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_s;
endpackage

// Enqueue, dequeue and fflags CSR signals between the aux stage, the buffer and the FP RF arbiter.
interface fpu_aux_wb_buffer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 33
);
    logic                    v_i;
    logic                    ready_o;
    logic [ADDR_W-1:0]       rd_i;
    logic [DATA_W-1:0]       result_i;
    fpu_aux_wb_pkg::fflags_s fflags_i;
    logic                    v_o;
    logic [ADDR_W-1:0]       rd_o;
    logic [DATA_W-1:0]       result_o;
    logic                    yumi_i;
    logic                    fflags_w_v_i;
    fpu_aux_wb_pkg::fflags_s fflags_w_data_i;
    fpu_aux_wb_pkg::fflags_s fflags_o;
    logic                    pending_o;

    modport slave (
        input  v_i, rd_i, result_i, fflags_i, yumi_i, fflags_w_v_i, fflags_w_data_i,
        output ready_o, v_o, rd_o, result_o, fflags_o, pending_o
    );

    modport master (
        output v_i, rd_i, result_i, fflags_i, yumi_i, fflags_w_v_i, fflags_w_data_i,
        input  ready_o, v_o, rd_o, result_o, fflags_o, pending_o
    );
endinterface

// File: rtl/fpu_aux_wb_buffer.sv
// 2-entry writeback FIFO behind the FPU aux stage; retires into the FP RF arbiter
// and folds retired fflags into a sticky accumulator.
module fpu_aux_wb_buffer #(
    parameter  int sig_width_p           = 23,
    parameter  int exp_width_p           = 9,
    parameter  int reg_addr_width_p      = 5,
    localparam int recoded_data_width_lp = 1 + sig_width_p + exp_width_p
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    fpu_aux_wb_buffer_if.slave   bus
);
    import fpu_aux_wb_pkg::*;

    logic [1:0][reg_addr_width_p-1:0]      r_rd_mem;
    logic [1:0][recoded_data_width_lp-1:0] r_res_mem;
    fflags_s [1:0]                         r_ff_mem;
    logic                                  r_wptr;
    logic                                  r_rptr;
    logic [1:0]                            r_cnt;
    fflags_s                               r_fflags;

    logic    w_ready;
    logic    w_v;
    logic    w_enq;
    logic    w_deq;
    fflags_s w_fflags_nxt;

    // Ready depends on occupancy only, so a full buffer never passes through.
    assign w_ready = (r_cnt != 2'd2);
    assign w_v     = (r_cnt != 2'd0);
    assign w_enq   = bus.v_i & w_ready;
    assign w_deq   = bus.yumi_i & w_v;

    // CSR write is the base; retiring flags are OR'd on top so neither is lost.
    assign w_fflags_nxt = fflags_s'((bus.fflags_w_v_i ? bus.fflags_w_data_i : r_fflags)
                                    | (w_deq ? r_ff_mem[r_rptr] : fflags_s'(5'b0)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_mem  <= '0;
            r_res_mem <= '0;
            r_ff_mem  <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= 2'd0;
            r_fflags  <= '0;
        end else begin
            if (w_enq) begin
                r_rd_mem[r_wptr]  <= bus.rd_i;
                r_res_mem[r_wptr] <= bus.result_i;
                r_ff_mem[r_wptr]  <= bus.fflags_i;
                r_wptr            <= ~r_wptr;
            end
            if (w_deq) r_rptr <= ~r_rptr;
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            r_fflags <= w_fflags_nxt;
        end
    end

    assign bus.ready_o   = w_ready;
    assign bus.v_o       = w_v;
    assign bus.pending_o = w_v;
    assign bus.rd_o      = r_rd_mem[r_rptr];
    assign bus.result_o  = r_res_mem[r_rptr];
    assign bus.fflags_o  = r_fflags;
endmodule
